uc_coordena_asteroides_tiros: RTL and testbench

//  Control unit started once per registered shot by the shot-registration FSM. Each pass it

---
 rtl/uc_coordena_asteroides_tiros.sv | 109 ++++++++++
 tb/tb_uc_coordena_asteroides_tiros.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/uc_coordena_asteroides_tiros.sv
// uc_coordena_asteroides_tiros: sequences one move/collision pass over the shot and asteroid slots.
// Strobes are decoded from the registered state and indices; the datapath applies them on the next edge.
module uc_coordena_asteroides_tiros #(
    parameter int N_AST = 8,
    parameter int N_TIROS = 4,
    parameter int VIDAS_INI = 3,
    localparam int AW = $clog2(N_AST),
    localparam int TW = $clog2(N_TIROS)
) (
    input  logic          i_clock,
    input  logic          i_reset,
    input  logic          i_iniciar,
    input  logic          i_asteroide_ativo,
    input  logic          i_tiro_ativo,
    input  logic          i_asteroide_na_nave,
    input  logic          i_colisao,
    output logic [AW-1:0] o_end_asteroide,
    output logic [TW-1:0] o_end_tiro,
    output logic          o_move_asteroide,
    output logic          o_move_tiro,
    output logic          o_destroi_asteroide,
    output logic          o_destroi_tiro,
    output logic [3:0]    o_vidas,
    output logic          o_acabou_vidas,
    output logic [7:0]    o_pontuacao,
    output logic          o_fim_movimentacao,
    output logic          o_ocupado,
    output logic [4:0]    o_db_estado
);
    typedef enum logic [2:0] {
        INICIAL    = 3'd0,
        MOVE_TIROS = 3'd1,
        MOVE_AST   = 3'd2,
        CHECA_NAVE = 3'd3,
        COLISAO    = 3'd4,
        FIM        = 3'd5
    } estado_t;

    estado_t       r_estado;
    logic [AW-1:0] r_end_ast;
    logic [TW-1:0] r_end_tiro;
    logic [3:0]    r_vidas;
    logic [7:0]    r_pontuacao;
    logic          w_last_ast;
    logic          w_last_tiro;
    logic          w_nave;
    logic          w_hit;

    assign w_last_ast  = r_end_ast == AW'(N_AST - 1);
    assign w_last_tiro = r_end_tiro == TW'(N_TIROS - 1);
    assign w_nave      = i_asteroide_ativo & i_asteroide_na_nave;
    assign w_hit       = i_asteroide_ativo & i_tiro_ativo & i_colisao;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_estado    <= INICIAL;
            r_end_ast   <= '0;
            r_end_tiro  <= '0;
            r_vidas     <= 4'(VIDAS_INI);
            r_pontuacao <= '0;
        end else begin
            case (r_estado)
                INICIAL: begin
                    r_end_ast  <= '0;
                    r_end_tiro <= '0;
                    if (i_iniciar) r_estado <= MOVE_TIROS;
                end
                MOVE_TIROS: begin
                    r_end_tiro <= w_last_tiro ? '0 : r_end_tiro + 1'b1;
                    r_end_ast  <= '0;
                    if (w_last_tiro) r_estado <= MOVE_AST;
                end
                MOVE_AST: r_estado <= CHECA_NAVE;
                CHECA_NAVE: begin
                    // the asteroid is destroyed even when no lives remain to lose
                    if (w_nave && r_vidas != 4'd0) r_vidas <= r_vidas - 1'b1;
                    r_end_ast  <= w_last_ast ? '0 : r_end_ast + 1'b1;
                    r_end_tiro <= '0;
                    r_estado   <= w_last_ast ? COLISAO : MOVE_AST;
                end
                COLISAO: begin
                    if (w_hit && r_pontuacao != 8'hff) r_pontuacao <= r_pontuacao + 1'b1;
                    r_end_tiro <= w_last_tiro ? '0 : r_end_tiro + 1'b1;
                    if (w_last_tiro) r_end_ast <= w_last_ast ? '0 : r_end_ast + 1'b1;
                    if (w_last_tiro && w_last_ast) r_estado <= FIM;
                end
                FIM: begin
                    r_end_ast  <= '0;
                    r_end_tiro <= '0;
                    r_estado   <= INICIAL;
                end
                default: r_estado <= INICIAL;
            endcase
        end
    end

    assign o_end_asteroide     = r_end_ast;
    assign o_end_tiro          = r_end_tiro;
    assign o_move_tiro         = (r_estado == MOVE_TIROS) & i_tiro_ativo;
    assign o_move_asteroide    = (r_estado == MOVE_AST) & i_asteroide_ativo;
    assign o_destroi_asteroide = ((r_estado == CHECA_NAVE) & w_nave) | ((r_estado == COLISAO) & w_hit);
    assign o_destroi_tiro      = (r_estado == COLISAO) & w_hit;
    assign o_vidas             = r_vidas;
    assign o_acabou_vidas      = r_vidas == 4'd0;
    assign o_pontuacao         = r_pontuacao;
    assign o_fim_movimentacao  = r_estado == FIM;
    assign o_ocupado           = r_estado != INICIAL;
    assign o_db_estado         = (r_estado > FIM) ? 5'b01101 : {2'b00, r_estado};
endmodule

// File: tb/tb_uc_coordena_asteroides_tiros.sv
// tb_uc_coordena_asteroides_tiros: directed vectors for the pass sequencer against a small slot-memory model.
module tb_uc_coordena_asteroides_tiros;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        iniciar = 1'b0;
    logic [7:0]  ast_cfg = '0, nave_cfg = '0, ast_kill = '0;
    logic [3:0]  tiro_cfg = '0, tiro_kill = '0;
    logic [31:0] col_cfg = '0;
    logic        kill_clr = 1'b0, cnt_clr = 1'b0;
    logic [2:0]  end_ast;
    logic [1:0]  end_tiro;
    logic        ast_at, tiro_at, na_nave, colisao;
    logic        move_ast, move_tiro, dest_ast, dest_tiro, acabou, fim, ocupado;
    logic [3:0]  vidas;
    logic [7:0]  pont;
    logic [4:0]  db;
    int n_ma = 0, n_mt = 0, n_da = 0, n_dt = 0, n_fim = 0;
    int la_st = 0, la_idx = 0, lt_idx = 0;
    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    uc_coordena_asteroides_tiros dut (
        .i_clock(clk), .i_reset(rst), .i_iniciar(iniciar),
        .i_asteroide_ativo(ast_at), .i_tiro_ativo(tiro_at),
        .i_asteroide_na_nave(na_nave), .i_colisao(colisao),
        .o_end_asteroide(end_ast), .o_end_tiro(end_tiro),
        .o_move_asteroide(move_ast), .o_move_tiro(move_tiro),
        .o_destroi_asteroide(dest_ast), .o_destroi_tiro(dest_tiro),
        .o_vidas(vidas), .o_acabou_vidas(acabou), .o_pontuacao(pont),
        .o_fim_movimentacao(fim), .o_ocupado(ocupado), .o_db_estado(db)
    );

    // slot memories: configured slots minus those destroyed during the pass
    assign ast_at  = ast_cfg[end_ast] & ~ast_kill[end_ast];
    assign tiro_at = tiro_cfg[end_tiro] & ~tiro_kill[end_tiro];
    assign na_nave = nave_cfg[end_ast];
    assign colisao = col_cfg[{end_ast, end_tiro}];

    always @(posedge clk) begin
        if (kill_clr) begin
            ast_kill  <= '0;
            tiro_kill <= '0;
        end else begin
            if (dest_ast) ast_kill[end_ast] <= 1'b1;
            if (dest_tiro) tiro_kill[end_tiro] <= 1'b1;
        end
        if (cnt_clr) begin
            n_ma <= 0; n_mt <= 0; n_da <= 0; n_dt <= 0; n_fim <= 0;
            la_st <= 0; la_idx <= 0; lt_idx <= 0;
        end else begin
            if (move_ast) n_ma <= n_ma + 1;
            if (move_tiro) n_mt <= n_mt + 1;
            if (dest_ast) begin
                n_da <= n_da + 1; la_st <= int'(db); la_idx <= int'(end_ast);
            end
            if (dest_tiro) begin
                n_dt <= n_dt + 1; lt_idx <= int'(end_tiro);
            end
            if (fim) n_fim <= n_fim + 1;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic setup(input logic r, input logic [7:0] a, input logic [7:0] n,
                         input logic [3:0] t, input logic [31:0] c);
        @(negedge clk);
        rst = r; ast_cfg = a; nave_cfg = n; tiro_cfg = t; col_cfg = c;
        kill_clr = 1'b1; cnt_clr = 1'b1;
        @(negedge clk);
        rst = 1'b0; kill_clr = 1'b0; cnt_clr = 1'b0;
    endtask

    // returns cycles from the sampling edge to fim (0 if it never came) and idle cycles seen while waiting
    task automatic run_pass(output int lat, output int busy_bad);
        lat = 0; busy_bad = 0;
        @(negedge clk); iniciar = 1'b1;
        @(negedge clk); iniciar = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            if (!ocupado) busy_bad++;
            if (fim) begin lat = c; break; end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    typedef struct {
        logic rst; logic [7:0] ast; logic [7:0] nave; logic [3:0] tiro; logic [31:0] col;
        int vidas; int pont; int da; int dt; int ma; int mt; int la_st; int la_idx; int lt_idx;
    } vec_t;
    vec_t v[8];

    initial begin
        int lat, bb;
        v[0] = '{1'b1, 8'h00, 8'h00, 4'h0, 32'h0,      3, 0, 0, 0, 0, 0, 0, 0, 0};
        v[1] = '{1'b1, 8'h20, 8'h20, 4'h1, 32'h100000, 2, 0, 1, 0, 1, 1, 3, 5, 0};
        v[2] = '{1'b1, 8'h0C, 8'h00, 4'h2, 32'h2200,   3, 1, 1, 1, 2, 1, 4, 2, 1};
        v[3] = '{1'b1, 8'h01, 8'h01, 4'h0, 32'h0,      2, 0, 1, 0, 1, 0, 3, 0, 0};
        v[4] = '{1'b0, 8'h80, 8'h80, 4'h0, 32'h0,      1, 0, 1, 0, 1, 0, 3, 7, 0};
        v[5] = '{1'b0, 8'h08, 8'h08, 4'h0, 32'h0,      0, 0, 1, 0, 1, 0, 3, 3, 0};
        v[6] = '{1'b0, 8'h02, 8'h02, 4'h0, 32'h0,      0, 0, 1, 0, 1, 0, 3, 1, 0};
        v[7] = '{1'b0, 8'h03, 8'h00, 4'hF, 32'h63,     0, 2, 2, 2, 2, 4, 4, 1, 1};

        setup(1'b1, 8'h00, 8'h00, 4'h0, 32'h0);
        chk("reset db_estado", int'(db), 0);
        chk("reset vidas", int'(vidas), 3);
        chk("reset pontuacao", int'(pont), 0);
        chk("reset ocupado", int'(ocupado), 0);
        chk("reset fim", int'(fim), 0);
        chk("reset indices", int'({end_ast, end_tiro}), 0);
        chk("reset acabou", int'(acabou), 0);

        for (int i = 0; i < 8; i++) begin
            setup(v[i].rst, v[i].ast, v[i].nave, v[i].tiro, v[i].col);
            run_pass(lat, bb);
            chk($sformatf("v%0d latency", i), lat, 53);
            chk($sformatf("v%0d ocupado gaps", i), bb, 0);
            chk($sformatf("v%0d idle after", i), int'(ocupado), 0);
            chk($sformatf("v%0d vidas", i), int'(vidas), v[i].vidas);
            chk($sformatf("v%0d acabou", i), int'(acabou), int'(v[i].vidas == 0));
            chk($sformatf("v%0d pontuacao", i), int'(pont), v[i].pont);
            chk($sformatf("v%0d destroi_ast", i), n_da, v[i].da);
            chk($sformatf("v%0d destroi_tiro", i), n_dt, v[i].dt);
            chk($sformatf("v%0d move_ast", i), n_ma, v[i].ma);
            chk($sformatf("v%0d move_tiro", i), n_mt, v[i].mt);
            chk($sformatf("v%0d fim pulses", i), n_fim, 1);
            if (v[i].da > 0) begin
                chk($sformatf("v%0d destroi_ast state", i), la_st, v[i].la_st);
                chk($sformatf("v%0d destroi_ast slot", i), la_idx, v[i].la_idx);
            end
            if (v[i].dt > 0) chk($sformatf("v%0d destroi_tiro slot", i), lt_idx, v[i].lt_idx);
        end

        // score saturation: four hits per pass, 64 passes reach 256 hits
        setup(1'b1, 8'h00, 8'h00, 4'h0, 32'h0);
        for (int p = 0; p < 65; p++) begin
            setup(1'b0, 8'h0F, 8'h00, 4'hF, 32'h8421);
            run_pass(lat, bb);
            if (p == 62) chk("pontuacao after 63 passes", int'(pont), 252);
            if (p == 63) chk("pontuacao saturates", int'(pont), 255);
        end
        chk("pontuacao stays saturated", int'(pont), 255);
        chk("hits still destroy at saturation", n_dt, 4);

        // iniciar held high through a whole pass
        setup(1'b1, 8'h00, 8'h00, 4'h0, 32'h0);
        @(negedge clk); iniciar = 1'b1;
        lat = 0;
        for (int c = 0; c <= 200; c++) begin
            @(negedge clk);
            if (fim) begin lat = c + 1; break; end
        end
        chk("held iniciar latency", lat, 53);
        chk("held fim db_estado", int'(db), 5);
        @(negedge clk);
        chk("held back to INICIAL", int'(db), 0);
        chk("held fim count", n_fim, 1);
        @(negedge clk); iniciar = 1'b0;
        chk("held restarts MOVE_TIROS", int'(db), 1);
        lat = 0;
        for (int c = 0; c <= 200; c++) begin
            @(negedge clk);
            if (fim) begin lat = c + 2; break; end
        end
        chk("held second pass latency", lat, 53);

        // reset in the tenth COLISAO cycle aborts the pass
        setup(1'b1, 8'h03, 8'h02, 4'h1, 32'h1);
        @(negedge clk); iniciar = 1'b1;
        @(negedge clk); iniciar = 1'b0;
        lat = 0;
        for (int c = 0; c < 200; c++) begin
            if (db == 5'd4) begin lat = 1; break; end
            @(negedge clk);
        end
        chk("reached COLISAO", lat, 1);
        repeat (9) @(negedge clk);
        chk("pre-reset pontuacao", int'(pont), 1);
        chk("pre-reset vidas", int'(vidas), 2);
        chk("pre-reset state", int'(db), 4);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("abort db_estado", int'(db), 0);
        chk("abort vidas", int'(vidas), 3);
        chk("abort pontuacao", int'(pont), 0);
        chk("abort ocupado", int'(ocupado), 0);
        repeat (60) @(negedge clk);
        chk("abort no fim", n_fim, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1);
    end
endmodule
